sseg_scan_driver: RTL and testbench
===================================

Name: sseg_scan_driver

Overview:
- Downstream display stage for the stopwatch: consumes four BCD time digits plus per-digit decimal-point flags and drives a 4-digit common-anode seven-segment display by time-multiplexing.
- Holds a frame-coherent display buffer so digits never tear mid-frame.
- Owns the refresh prescaler, anode rotation, BCD-to-segment decode and registered pin outputs.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency.
- DIGIT_HZ, 1000, per-digit slot rate; one full frame = 4 slots.
- DIV, CLK_HZ/DIGIT_HZ, derived localparam: clocks per slot; must be >= 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- digits_in  in  16  four BCD digits; [3:0] = digit 0 (rightmost) ... [15:12] = digit 3.
- dp_in  in  4  decimal-point enable per digit; bit i = digit i.
- load  in  1  single-cycle strobe; captures digits_in/dp_in.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  4  anode enables, active-low; bit i = digit i.
- dp  out  1  decimal point, active-low.
- frame_tick  out  1  one-cycle pulse at each frame start (digit 0 slot begins).

Behaviour:
- Clock/reset: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset values: an=4'b1111, seg=7'b1111111, dp=1, frame_tick=0, prescaler=0, digit_idx=0, pending and active buffers = 0 (digits and dp).
- Prescaler: counts 0..DIV-1 and wraps; slot_end asserts when count==DIV-1.
- Scan state: digit_idx is a 2-bit counter over 0→1→2→3→0 that advances on slot_end. There is no other state; there are no idle states.
- Frame boundary: slot_end while digit_idx==3. On that cycle active <= pending, and frame_tick is registered high for the next cycle, which aligns with the first digit-0 cycle.
- Load: when load=1, pending <= {digits_in, dp_in}. Load is accepted every cycle and there is no backpressure. Multiple loads within a frame keep only the last one.
- Load on the frame-boundary cycle: active takes digits_in/dp_in directly (bypass), and pending is updated as well. The new value shows in the frame that starts next.
- Outputs are registered with latency 1 clk from a digit_idx change to the pins:
  - an = ~(1<<digit_idx)
  - seg = decode(active digit[digit_idx])
  - dp = ~active_dp[digit_idx]
- Decode, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - 0xA–0xE = 0111111 (dash, segment g only).
  - 0xF = 1111111 (blank); anode is still driven.
- Exactly one anode bit is low at every cycle after the first post-reset clock.
- Reset asserted mid-frame: all outputs go to reset values immediately (async). After release, scanning restarts at digit 0 with a full DIV-cycle slot, and buffers are cleared, so the display shows 0000 with no dp.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: a digit i (i=3..1) whose active value is 0 and whose higher digits are all 0 (or already blanked) decodes as blank (seg=1111111). Its dp still follows active_dp. Digit 0 is never blanked. Example: 0x0070 shows " 70" with digit 0 = '0'.
- Undefined: all digits are decoded literally, so zeros show as '0'.

Decomposition:
- Package sseg_pkg:
  - typedef logic [3:0] bcd_t.
  - typedef logic [6:0] seg_t.
  - constants SEG_BLANK, SEG_DASH, SEG_DIGIT[0:9].
  - NUM_DIGITS=4.
- Sub-module: sseg_decoder, purely combinational: bcd_t + blank flag → seg_t. It is instantiated once in the scan path; the rest (prescaler, scan counter, buffers, output registers) stays in sseg_scan_driver.

Test Plan:
All scenarios use CLK_HZ=16 and DIGIT_HZ=4, so DIV=4.
- Reset then idle 40 clks → an cycles 1110,1101,1011,0111 every 4 clks; seg=1000000 on every digit; dp=1; frame_tick pulses every 16 clks, coincident with an=1110.
- load with digits_in=16'h1234, dp_in=4'b0100, mid-frame → the current frame is unchanged. The next frame shows digit0 seg=0011001 ('4'), digit1 '3', digit2 '2' with dp=0, digit3 '1'.
- load asserted exactly on the frame-boundary cycle with 16'h9876 → the very next digit-0 slot shows '6' (bypass path).
- digits_in=16'hFA05 → digit3 blank with an still low, digit2 dash 0111111, digit1 '0', digit0 '5'.
- Reset pulsed in the middle of a digit-2 slot → an=1111 and seg=1111111 within the same cycle. After release, an=1110 holds for exactly 4 clks, and the display shows 0000 again.
- With LEADING_ZERO_BLANK_EN, load 16'h0070 → digit3 blank, digit2 '0'→ blank? No: digit2=0 and higher zero → blank; digit1 '7', digit0 '0'. Load 16'h0000 → only digit0 '0' is visible.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared types and segment patterns for the seven-segment scan driver.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package sseg_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  localparam int NUM_DIGITS = 4;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_DASH  = 7'b0111111;

  localparam seg_t SEG_DIGIT [0:9] = '{
    7'b1000000,
    7'b1111001,
    7'b0100100,
    7'b0110000,
    7'b0011001,
    7'b0010010,
    7'b0000010,
    7'b1111000,
    7'b0000000,
    7'b0010000
  };

endpackage

// File: rtl/sseg_decoder.sv
// Combinational BCD-to-segment decode, active-low outputs.
// 0xA-0xE render as a dash, 0xF and a raised blank flag render as all-off.
module sseg_decoder
  import sseg_pkg::*;
(
  input  bcd_t bcd,
  input  logic blank,
  output seg_t seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      if (bcd <= 4'd9) begin
        seg = SEG_DIGIT[bcd];
      end else if (bcd != 4'hF) begin
        seg = SEG_DASH;
      end
    end
  end

endmodule

// File: rtl/sseg_scan_driver.sv
// Four-digit common-anode multiplexed display driver with a frame-coherent buffer.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zeros on digits 3..1.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int DIGIT_HZ = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_tick
);

  // DIV must be at least 2 so the prescaler has a real wrap point.
  localparam int DIV   = CLK_HZ / DIGIT_HZ;
  localparam int CNT_W = $clog2(DIV);

  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_nxt;
  logic [1:0]            digit_idx;
  logic [1:0]            digit_idx_nxt;
  logic                  slot_end;
  logic                  frame_end;

  logic [15:0]           pend_digits;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic [15:0]           act_digits;
  logic [NUM_DIGITS-1:0] act_dp;

  logic                  frame_d;
  logic [NUM_DIGITS-1:0] lz_blank;
  bcd_t                  cur_bcd;
  logic                  cur_blank;
  seg_t                  cur_seg;
  logic [3:0]            an_nxt;
  logic                  dp_nxt;

  assign slot_end  = (count == CNT_W'(DIV - 1));
  assign frame_end = slot_end && (digit_idx == 2'd3);

  // Scan state register: prescaler and digit index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      digit_idx <= 2'd0;
    end else begin
      count     <= count_nxt;
      digit_idx <= digit_idx_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    count_nxt     = slot_end ? '0 : count + CNT_W'(1);
    digit_idx_nxt = slot_end ? digit_idx + 2'd1 : digit_idx;
  end

  // Pending buffer takes every load; active is swapped only at the frame
  // boundary, with a same-cycle load bypassing pending so it is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_digits <= '0;
      pend_dp     <= '0;
      act_digits  <= '0;
      act_dp      <= '0;
    end else begin
      if (load) begin
        pend_digits <= digits_in;
        pend_dp     <= dp_in;
      end
      if (frame_end) begin
        act_digits <= load ? digits_in : pend_digits;
        act_dp     <= load ? dp_in     : pend_dp;
      end
    end
  end

  always_comb begin
    lz_blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
    lz_blank[3] = (act_digits[15:12] == 4'd0);
    lz_blank[2] = lz_blank[3] && (act_digits[11:8] == 4'd0);
    lz_blank[1] = lz_blank[2] && (act_digits[7:4] == 4'd0);
`endif
  end

  // Output logic: values the pins take on the next clock.
  always_comb begin
    cur_bcd   = act_digits[{digit_idx, 2'b00} +: 4];
    cur_blank = lz_blank[digit_idx];
    an_nxt    = ~(4'b0001 << digit_idx);
    dp_nxt    = ~act_dp[digit_idx];
  end

  sseg_decoder u_decoder (
    .bcd   (cur_bcd),
    .blank (cur_blank),
    .seg   (cur_seg)
  );

  // frame_tick is delayed one extra cycle so it coincides with the first
  // cycle the digit-0 anode is actually driven at the pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an         <= 4'b1111;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_d    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_nxt;
      seg        <= cur_seg;
      dp         <= dp_nxt;
      frame_d    <= frame_end;
      frame_tick <= frame_d;
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Self-checking bench for sseg_scan_driver with DIV=4 (16 clocks per frame).
// Reference model works on edge counts since reset release, not on RTL state.
module tb_sseg_scan_driver;

  logic        clk;
  logic        reset;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        load;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  int n = 0;
  logic [19:0] cur;
  logic [19:0] snap;
  logic [19:0] shown;

  sseg_scan_driver #(.CLK_HZ(16), .DIGIT_HZ(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .load       (load),
    .seg        (seg),
    .an         (an),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dpv;
    logic [27:0] exp_seg;
    logic [3:0]  exp_dp;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [15:0] v, input int d);
    logic [3:0] b;
    b = v[d*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && (v >> (4*d)) == 16'd0) return 7'b1111111;
`endif
    case (b)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      4'hF: return 7'b1111111;
      default: return 7'b0111111;
    endcase
  endfunction

  // One clock: update the model from the inputs sampled at this edge, then compare.
  task automatic tick();
    logic        lv;
    logic [19:0] lval;
    int          d;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_ft;
    lv   = load;
    lval = {digits_in, dp_in};
    @(posedge clk);
    n++;
    if (lv) cur = lval;
    if (n % 16 == 0) snap = cur;
    if (n > 1 && (n - 1) % 16 == 0) shown = snap;
    #1;
    d     = ((n - 1) / 4) % 4;
    e_an  = 4'b1111;
    e_an[d] = 1'b0;
    e_seg = ref_seg(shown[19:4], d);
    e_dp  = ~shown[d];
    e_ft  = (n > 1 && (n - 1) % 16 == 0);
    check("an", {28'd0, an}, {28'd0, e_an});
    check("seg", {25'd0, seg}, {25'd0, e_seg});
    check("dp", {31'd0, dp}, {31'd0, e_dp});
    check("frame_tick", {31'd0, frame_tick}, {31'd0, e_ft});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_an"}, {28'd0, an}, 32'hF);
    check({tag, "_seg"}, {25'd0, seg}, 32'h7F);
    check({tag, "_dp"}, {31'd0, dp}, 32'd1);
    check({tag, "_ft"}, {31'd0, frame_tick}, 32'd0);
  endtask

  task automatic model_clear();
    n = 0;
    cur = '0;
    snap = '0;
    shown = '0;
  endtask

  initial begin
    int target;
    int d;
    int guard;
    int an0_cnt;

    vecs[0] = '{16'h1234, 4'b0100, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1011};
    vecs[1] = '{16'hFA05, 4'b0000, {7'b1111111, 7'b0111111, 7'b1000000, 7'b0010010}, 4'b1111};
    vecs[2] = '{16'h9876, 4'b0001, {7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010}, 4'b1110};
`ifdef LEADING_ZERO_BLANK_EN
    vecs[3] = '{16'h0070, 4'b0100, {7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000}, 4'b1011};
    vecs[4] = '{16'h0000, 4'b1000, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b0111};
`else
    vecs[3] = '{16'h0070, 4'b0100, {7'b1000000, 7'b1000000, 7'b1111000, 7'b1000000}, 4'b1011};
    vecs[4] = '{16'h0000, 4'b1000, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b0111};
`endif
    vecs[5] = '{16'h8BCD, 4'b1111, {7'b0000000, 7'b0111111, 7'b0111111, 7'b0111111}, 4'b0000};

    reset = 1'b1;
    load = 1'b0;
    digits_in = '0;
    dp_in = '0;
    model_clear();
    #1;
    check_reset_vals("rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_vals("rst_hold");
    reset = 1'b0;

    // Idle scan after reset.
    for (int i = 0; i < 40; i++) tick();

    // Table vectors: load mid-frame, then verify the following frame.
    foreach (vecs[v]) begin
      guard = 0;
      while (n % 16 != 6 && guard < 32) begin
        tick();
        guard++;
      end
      check("tbl_align", {31'd0, guard < 32}, 32'd1);
      digits_in = vecs[v].digits;
      dp_in = vecs[v].dpv;
      load = 1'b1;
      tick();
      load = 1'b0;
      digits_in = 16'h5555;
      dp_in = 4'b1010;
      target = (n - 1) / 16 + 1;
      for (int i = 0; i < 40; i++) begin
        tick();
        if ((n - 1) / 16 == target && (n - 1) % 4 == 0) begin
          d = ((n - 1) / 4) % 4;
          check("tbl_seg", {25'd0, seg}, {25'd0, vecs[v].exp_seg[d*7 +: 7]});
          check("tbl_dp", {31'd0, dp}, {31'd0, vecs[v].exp_dp[d]});
        end
      end
    end

    // Load on the frame-boundary cycle takes the bypass path.
    guard = 0;
    while (n % 16 != 15 && guard < 32) begin
      tick();
      guard++;
    end
    digits_in = 16'h9876;
    dp_in = 4'b0000;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    check("bypass_an", {28'd0, an}, 32'hE);
    check("bypass_seg", {25'd0, seg}, 32'h02);
    for (int i = 0; i < 20; i++) tick();

    // Randomized loads, including repeated loads within one frame.
    for (int i = 0; i < 300; i++) begin
      load = ($urandom_range(3) == 0);
      digits_in = 16'($urandom);
      dp_in = 4'($urandom);
      tick();
    end
    load = 1'b0;

    // Reset pulsed in the middle of a digit-2 slot.
    digits_in = 16'h1234;
    dp_in = 4'b1111;
    load = 1'b1;
    tick();
    load = 1'b0;
    guard = 0;
    while (!((n - 1) / 16 >= 1 && ((n - 1) / 4) % 4 == 2 && (n - 1) % 4 == 1) && guard < 64) begin
      tick();
      guard++;
    end
    check("mid_align", {31'd0, guard < 64}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    @(posedge clk);
    #1;
    check_reset_vals("mid_rst_hold");
    reset = 1'b0;
    model_clear();
    an0_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i < 8 && an == 4'b1110) an0_cnt++;
    end
    check("post_rst_slot_len", an0_cnt, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
